atmos_light_estimator: RTL

- Streaming estimator that produces the atmospheric light (ar, ag, ab) consumed by psi_calculator.
- Scans one frame of RGB pixels and selects the pixel with the brightest dark channel, min(r,g,b).
- At end of frame, temporally smooths the result against previous frames, applies a floor, and emits a one-cycle valid strobe for psi_calculator's valid_in.

---
 rtl/atmos_light_estimator.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/atmos_light_estimator.sv
// Atmospheric light estimator.
// Scans one RGB frame and keeps the pixel with the brightest dark channel, min(r,g,b). When
// the sum r+g+b ties on the dark channel, the larger sum wins; full ties keep the earlier
// pixel. At end of frame the winner is IIR-smoothed against earlier frames, floored, and
// presented with a one-cycle valid_out strobe.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   pix_r/g/b, pix_valid  pixel stream; accepted when pix_valid && in_ready
//   sof, eof              first / last pixel of frame (qualified by pix_valid)
//   in_ready              low only during the single UPDATE cycle
//   ar, ag, ab            atmospheric light; held between frames
//   valid_out             one-cycle pulse when ar/ag/ab are updated
//   sof_err               one-cycle pulse when sof arrives mid-frame
module atmos_light_estimator #(
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter logic [7:0]  A_FLOOR      = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  input  logic       pix_valid,
  input  logic       sof,
  input  logic       eof,
  output logic       in_ready,
  output logic [7:0] ar,
  output logic [7:0] ag,
  output logic [7:0] ab,
  output logic       valid_out,
  output logic       sof_err
);

  typedef enum logic [1:0] {StIdle, StScan, StUpdate} state_e;

  state_e     state_q, state_d;
  logic [7:0] cand_r_q, cand_g_q, cand_b_q;
  logic [7:0] sa_r_q, sa_g_q, sa_b_q;
  logic [7:0] sa_r_n, sa_g_n, sa_b_n;
  logic [7:0] ar_q, ag_q, ab_q;
  logic       first_done_q;
  logic       valid_q;
  logic       sof_err_q, sof_err_d;
  logic       load;
  logic       accept;
  logic       better;
  logic [7:0] pix_dk, cand_dk;
  logic [9:0] pix_sum, cand_sum;

  function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    logic [7:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [9:0] sum3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return {2'b00, a} + {2'b00, b} + {2'b00, c};
  endfunction

  // sa + ((cand - sa) >>> SMOOTH_SHIFT); the step never leaves 0..255, so 8-bit wrap is exact.
  function automatic logic [7:0] smooth(input logic [7:0] sa, input logic [7:0] cand);
    logic signed [8:0] diff;
    logic signed [8:0] step;
    diff = $signed({1'b0, cand}) - $signed({1'b0, sa});
    step = diff >>> SMOOTH_SHIFT;
    return sa + step[7:0];
  endfunction

  function automatic logic [7:0] floor_a(input logic [7:0] x);
    return (x < A_FLOOR) ? A_FLOOR : x;
  endfunction

  assign in_ready = (state_q != StUpdate);
  assign accept   = pix_valid && in_ready;

  assign pix_dk   = min3(pix_r, pix_g, pix_b);
  assign cand_dk  = min3(cand_r_q, cand_g_q, cand_b_q);
  assign pix_sum  = sum3(pix_r, pix_g, pix_b);
  assign cand_sum = sum3(cand_r_q, cand_g_q, cand_b_q);
  assign better   = (pix_dk > cand_dk) || ((pix_dk == cand_dk) && (pix_sum > cand_sum));

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    sof_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && sof) begin
          load    = 1'b1;
          state_d = eof ? StUpdate : StScan;
        end
      end
      StScan: begin
        if (accept) begin
          if (sof) begin
            // Restart: the partial frame so far is discarded.
            load      = 1'b1;
            sof_err_d = 1'b1;
          end else if (better) begin
            load = 1'b1;
          end
          if (eof) state_d = StUpdate;
        end
      end
      StUpdate: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // The very first frame seeds the smoothing state directly.
  assign sa_r_n = first_done_q ? smooth(sa_r_q, cand_r_q) : cand_r_q;
  assign sa_g_n = first_done_q ? smooth(sa_g_q, cand_g_q) : cand_g_q;
  assign sa_b_n = first_done_q ? smooth(sa_b_q, cand_b_q) : cand_b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cand_r_q     <= 8'd0;
      cand_g_q     <= 8'd0;
      cand_b_q     <= 8'd0;
      sa_r_q       <= 8'd0;
      sa_g_q       <= 8'd0;
      sa_b_q       <= 8'd0;
      ar_q         <= 8'd0;
      ag_q         <= 8'd0;
      ab_q         <= 8'd0;
      first_done_q <= 1'b0;
      valid_q      <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sof_err_q <= sof_err_d;
      valid_q   <= (state_q == StUpdate);
      if (load) begin
        cand_r_q <= pix_r;
        cand_g_q <= pix_g;
        cand_b_q <= pix_b;
      end
      if (state_q == StUpdate) begin
        sa_r_q       <= sa_r_n;
        sa_g_q       <= sa_g_n;
        sa_b_q       <= sa_b_n;
        first_done_q <= 1'b1;
        // Floor applies to the outputs only; the smoothing state stays unclamped.
        ar_q         <= floor_a(sa_r_n);
        ag_q         <= floor_a(sa_g_n);
        ab_q         <= floor_a(sa_b_n);
      end
    end
  end

  assign ar        = ar_q;
  assign ag        = ag_q;
  assign ab        = ab_q;
  assign valid_out = valid_q;
  assign sof_err   = sof_err_q;

endmodule
